// File: rtl/shift_pkg.sv
// shift_pkg: shift encodings, FSM state type, step size and start-time decode shared by shift_seq
package shift_pkg;

    localparam int STEP = 4;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } sh_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [4:0]  e;
        logic [31:0] res;
        logic        c;
    } dec_t;

    // Effective step count plus the result/carry used when no stepping is needed (e == 0)
    function automatic dec_t decode(input logic [31:0] op, input logic [1:0] sh,
                                    input logic [7:0] amt, input logic cin);
        dec_t d;
        d = '{e: 5'd0, res: op, c: cin};
        if (amt != 8'd0) begin
            if (sh == SH_ROR) begin
                if (amt[4:0] == 5'd0)
                    d.c = op[31];
                else
                    d.e = amt[4:0];
            end else if (amt < 8'd32) begin
                d.e = amt[4:0];
            end else if (sh == SH_ASR) begin
                d.res = {32{op[31]}};
                d.c   = op[31];
            end else begin
                d.res = '0;
                d.c   = (amt == 8'd32) && (sh == SH_LSL ? op[0] : op[31]);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/shift_core.sv
// shift_core: combinational 32-bit shifter by 0..4 positions with carry in/out
module shift_core
    import shift_pkg::*;
(
    input  logic [31:0] x_i,
    input  logic [1:0]  sh_i,
    input  logic [2:0]  amt_i,
    input  logic        c_i,
    output logic [31:0] y_o,
    output logic        c_o
);

    logic [32:0] lsl;
    logic [32:0] lsr;
    logic [32:0] asr;
    logic [31:0] ror;

    // Carry rides in the extra bit so a zero-amount shift passes c_i straight through
    assign lsl = {c_i, x_i} << amt_i;
    assign lsr = {x_i, c_i} >> amt_i;
    assign asr = 33'($signed({x_i, c_i}) >>> amt_i);
    assign ror = 32'({x_i, x_i} >> amt_i);

    // Select shift type; carry is the last bit shifted out
    always_comb begin
        y_o = sh_i == SH_LSL ? lsl[31:0] : sh_i == SH_LSR ? lsr[32:1] : sh_i == SH_ASR ? asr[32:1] : ror;
        c_o = sh_i == SH_LSL ? lsl[32] : sh_i == SH_LSR ? lsr[0] : sh_i == SH_ASR ? asr[0] : (amt_i == 3'd0 ? c_i : ror[31]);
    end

endmodule

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle barrel-shift sequencer, up to 4 bit positions per cycle; SHIFT_SEQ_RRX_EN enables rotate-right-extended
module shift_seq
    import shift_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [1:0]  sh,
    input  logic [7:0]  amt,
    input  logic        carry_in,
    input  logic        rrx,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        carry_out
);

    state_e      state_q;
    logic [4:0]  rem_q;
    logic [31:0] w_q;
    logic        c_q;
    logic [1:0]  sh_q;
    logic [31:0] result_q;
    logic        carry_q;
    logic        busy_q;
    logic        done_q;
    dec_t        dec_d;
    logic [2:0]  step_d;
    logic [31:0] y_d;
    logic        cy_d;

`ifdef SHIFT_SEQ_RRX_EN
    assign dec_d = rrx ? dec_t'{e: 5'd0, res: {carry_in, op_a[31:1]}, c: op_a[0]}
                       : decode(op_a, sh, amt, carry_in);
`else
    logic unused_rrx;
    assign unused_rrx = rrx;
    assign dec_d = decode(op_a, sh, amt, carry_in);
`endif

    assign step_d = rem_q > 5'(STEP) ? 3'(STEP) : rem_q[2:0];

    shift_core u_core (
        .x_i  (w_q),
        .sh_i (sh_q),
        .amt_i(step_d),
        .c_i  (c_q),
        .y_o  (y_d),
        .c_o  (cy_d)
    );

    // Sequencer: accept in IDLE, step the working register in RUN, publish on entry to DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            w_q      <= '0;
            c_q      <= 1'b0;
            sh_q     <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !flush) begin
                        w_q    <= op_a;
                        sh_q   <= sh;
                        c_q    <= carry_in;
                        rem_q  <= dec_d.e;
                        busy_q <= 1'b1;
                        if (dec_d.e == 5'd0) begin
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                            result_q <= dec_d.res;
                            carry_q  <= dec_d.c;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        rem_q   <= '0;
                    end else begin
                        w_q   <= y_d;
                        c_q   <= cy_d;
                        rem_q <= rem_q - 5'(step_d);
                        if (rem_q <= 5'(STEP)) begin
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                            result_q <= y_d;
                            carry_q  <= cy_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_q;

endmodule
